// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It turns the ID hazard,
// EXE branch-taken and MEM busy flags into per-stage freeze, flush and
// bubble controls. It also keeps saturating stall/flush counters and a
// sticky watchdog that trips when the memory stays busy for too long.
module pipeline_stall_ctrl #(
  parameter int BR_FLUSH_CYCLES = 1,    // IF/ID flush cycles per taken branch, 1..7
  parameter int MEM_TIMEOUT     = 255,  // busy cycles before the watchdog trips, 1..65535
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active low
  input  logic             hazard_detected,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_pipe,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HAZ      = 2'd3
  } state_e;

  localparam logic [2:0]  REM_INIT = 3'(BR_FLUSH_CYCLES - 1);
  localparam logic [15:0] WD_MAX   = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [15:0]      wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic fpc_c, fif_c, flush_c, bubble_c, fpipe_c, br_acc_c;

  // Next state and control outputs, in priority order:
  // memory busy, then taken branch, then pending flush cycles, then hazard.
  // A leftover flush remainder is therefore resumed straight out of
  // MEM_WAIT, and the next state follows the remainder after this cycle.
  always_comb begin
    state_d  = RUN;
    rem_d    = rem_q;
    fpc_c    = 1'b0;
    fif_c    = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    fpipe_c  = 1'b0;
    br_acc_c = 1'b0;
    if (mem_busy) begin
      fpc_c   = 1'b1;
      fif_c   = 1'b1;
      fpipe_c = 1'b1;
      state_d = MEM_WAIT;
    end else if (br_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      br_acc_c = 1'b1;
      rem_d    = REM_INIT;
      state_d  = (REM_INIT != 3'd0) ? FLUSH : RUN;
    end else if (rem_q != 3'd0) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      rem_d    = rem_q - 3'd1;
      state_d  = (rem_q != 3'd1) ? FLUSH : RUN;
    end else if (hazard_detected) begin
      fpc_c    = 1'b1;
      fif_c    = 1'b1;
      bubble_c = 1'b1;
      state_d  = HAZ;
    end
  end

  // Watchdog and saturating performance counters.
  always_comb begin
    wd_d        = 16'd0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_busy) begin
      wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 16'd1;
      if (wd_d == WD_MAX) timeout_d = 1'b1;
    end
    if (fpc_c && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
    if (br_acc_c && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State, flush remainder, watchdog and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      rem_q       <= 3'd0;
      wd_q        <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced low while reset is held, whatever the inputs do.
  assign freeze_pc    = fpc_c    & rst;
  assign freeze_if_id = fif_c    & rst;
  assign flush_if_id  = flush_c  & rst;
  assign bubble_id_ex = bubble_c & rst;
  assign freeze_pipe  = fpipe_c  & rst;
  assign state        = state_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign mem_timeout  = timeout_q;

endmodule
